regfile_write_port: RTL
=======================

Name: regfile_write_port

Overview:
- Write-side companion to the register file's read mux tree.
- Accepts write-back requests from the WB stage through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into a registered one-hot write-enable vector and a data bus that feed the 32 x 64-bit register array.
- Provides two bypass ports so the read path sees writes that are still pending.

Parameters:
- NUM_REGS, 32: number of architectural registers. Must equal 2**ADDR_W.
- ADDR_W, 5: register address width.
- DATA_W, 64: register data width.
- DEPTH, 2: write-buffer entries. Must be a power of 2, at least 2.
- ZERO_REG, 31: index of the hardwired-zero register (XZR).

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- wr_valid, input, 1: write request valid.
- wr_ready, output, 1: buffer can accept a request.
- wr_addr, input, ADDR_W: destination register.
- wr_data, input, DATA_W: write data.
- reg_en, output, NUM_REGS: registered one-hot write enable to the array.
- reg_wdata, output, DATA_W: registered write data to the array.
- pend_cnt, output, $clog2(DEPTH)+1: FIFO occupancy.
- rd_addr_a, input, ADDR_W: read port A address, for bypass compare.
- rd_addr_b, input, ADDR_W: read port B address, for bypass compare.
- byp_hit_a, output, 1: port A address matches a pending write.
- byp_hit_b, output, 1: port B address matches a pending write.
- byp_data_a, output, DATA_W: forwarded data for port A; 0 when no hit.
- byp_data_b, output, DATA_W: forwarded data for port B; 0 when no hit.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on reset_n.
- Reset values: FIFO count, head and tail pointers = 0; reg_en = 0; reg_wdata = 0; all entry valid bits = 0.
- wr_ready is 0 while reset_n is low, and 1 in the first cycle after deassertion.
- Handshake:
  - A push occurs on a posedge where wr_valid && wr_ready.
  - wr_ready = (pend_cnt != DEPTH) and is combinational from state only; there is no combinational path from wr_valid.
  - wr_addr and wr_data are sampled only on a push. While wr_ready=0 the requester holds its request.
- Drain:
  - On every posedge with pend_cnt > 0, the head is popped: reg_en <= one-hot(head addr) and reg_wdata <= head data.
  - With pend_cnt = 0: reg_en <= 0 and reg_wdata holds its value.
- Latency:
  - A request accepted at edge N appears on reg_en/reg_wdata after edge N+1.
  - The array captures it at edge N+2.
  - A request pushed at edge N cannot be popped at edge N (no same-edge fall-through).
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full, but wr_ready is still 0 when full, so no push occurs that cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count distinguishes full from empty.
- Bypass, evaluated independently per port, combinational from rd_addr_x and state:
  - Candidates are all valid FIFO entries plus the output stage (the address encoded in reg_en, when reg_en != 0).
  - Priority is youngest first: newest FIFO entry, then older FIFO entries, then the output stage.
  - rd_addr_x == ZERO_REG never hits: byp_hit_x = 0 and byp_data_x = 0.
  - An incoming wr_valid request that has not yet been pushed is not a bypass candidate.
- Duplicate addresses: two pending writes to the same register commit in order. Bypass returns the younger one.
- Reset mid-operation: pending entries are discarded and reg_en clears immediately (asynchronously). No partial write is emitted after reset deasserts.
- reg_en is always zero or one-hot; it is never multi-hot.

Optional Feature:
- Macro: REGFILE_XZR_DROP_EN
- Defined: a handshake with wr_addr == ZERO_REG completes normally (wr_ready behaves as usual) but nothing is enqueued. pend_cnt does not change, and reg_en[ZERO_REG] is never asserted.
- Undefined: ZERO_REG writes are enqueued and drained like any other register, so reg_en[ZERO_REG] pulses. The array is responsible for ignoring them.
- Bypass never hits ZERO_REG in either build.

Test Plan:
1. Reset then single write: release reset_n; push addr=3, data=0xDEAD_BEEF at edge 1 -> reg_en=0x0000_0008, reg_wdata=0xDEADBEEF after edge 2; reg_en=0 after edge 3; pend_cnt sequence 1,0.
2. Back-to-back fill: push addr=1, 2, 3 on consecutive cycles with wr_valid held -> all three accepted in order without overflow; reg_en sequence 0x2, 0x4, 0x8 with no gaps; pend_cnt never exceeds 2.
3. Bypass priority: push addr=5 data=0x11, then addr=5 data=0x22 on the next cycle; set rd_addr_a=5 -> byp_hit_a=1, byp_data_a=0x22 while both are pending; after the first entry drains, still 0x22; after both drain, byp_hit_a=0.
4. Zero register: push addr=31, data=0xFF; rd_addr_b=31 -> byp_hit_b=0 in both builds. With REGFILE_XZR_DROP_EN: pend_cnt stays 0 and reg_en stays 0. Without it: reg_en=0x8000_0000 one cycle later.
5. Reset mid-operation: fill the buffer with 2 entries, pulse reset_n low between edges -> reg_en=0 and pend_cnt=0 immediately; after release, no reg_en pulse occurs.
6. Wrap-around: 10 sequential single writes to addresses 0..9 with random 64-bit data -> each appears exactly once on reg_en/reg_wdata in order, and pointers wrap correctly.

Source files
------------

// File: rtl/regfile_write_port_if.sv
// Write-port bus: WB-stage valid/ready write request, array write outputs,
// FIFO occupancy and the two read-side bypass ports.
interface regfile_write_port_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] reg_en;
  logic [DATA_W-1:0]   reg_wdata;
  logic [CNT_W-1:0]    pend_cnt;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic                byp_hit_a;
  logic                byp_hit_b;
  logic [DATA_W-1:0]   byp_data_a;
  logic [DATA_W-1:0]   byp_data_b;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output wr_ready, reg_en, reg_wdata, pend_cnt,
           byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  wr_ready, reg_en, reg_wdata, pend_cnt,
           byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
  );
endinterface

// File: rtl/regfile_write_port.sv
// Register-file write port: small write-back FIFO drained one entry per cycle
// into a registered one-hot enable, with youngest-first bypass for two read ports.
// Define REGFILE_XZR_DROP_EN to silently drop writes to the zero register.
module regfile_write_port #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_write_port_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] reg_en_q;
  logic [DATA_W-1:0]   reg_wdata_q;

  logic                ready;
  logic                push;
  logic                enq;
  logic                pop;

  logic [ADDR_W-1:0]   rd [2];
  logic [1:0]          hit;
  logic [DATA_W-1:0]   hdata [2];
  logic [PTR_W-1:0]    idx;

  // Gating with reset_n keeps wr_ready low for the whole reset window.
  assign ready = reset_n && (cnt_q != FULL_CNT);
  assign push  = bus.wr_valid && ready;
  assign pop   = (cnt_q != '0);

`ifdef REGFILE_XZR_DROP_EN
  assign enq = push && (bus.wr_addr != ZERO_ADDR);
`else
  assign enq = push;
`endif

  assign cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(pop);

  always_comb begin
    vld_d = vld_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (enq) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      reg_en_q    <= '0;
      reg_wdata_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      if (pop) begin
        reg_en_q    <= NUM_REGS'(1) << addr_q[head_q];
        reg_wdata_q <= data_q[head_q];
        head_q      <= head_q + PTR_W'(1);
      end else begin
        reg_en_q    <= '0;
      end
      if (enq) begin
        addr_q[tail_q] <= bus.wr_addr;
        data_q[tail_q] <= bus.wr_data;
        tail_q         <= tail_q + PTR_W'(1);
      end
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd[0] = bus.rd_addr_a;
  assign rd[1] = bus.rd_addr_b;

  // Output stage first, then FIFO oldest to newest so the youngest match wins.
  always_comb begin
    hit      = '0;
    hdata[0] = '0;
    hdata[1] = '0;
    idx      = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd[p] != ZERO_ADDR) begin
        if (reg_en_q[rd[p]]) begin
          hit[p]   = 1'b1;
          hdata[p] = reg_wdata_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_q + PTR_W'(k);
          if (vld_q[idx] && (addr_q[idx] == rd[p])) begin
            hit[p]   = 1'b1;
            hdata[p] = data_q[idx];
          end
        end
      end
    end
  end

  assign bus.wr_ready   = ready;
  assign bus.reg_en     = reg_en_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.pend_cnt   = cnt_q;
  assign bus.byp_hit_a  = hit[0];
  assign bus.byp_hit_b  = hit[1];
  assign bus.byp_data_a = hdata[0];
  assign bus.byp_data_b = hdata[1];

endmodule
